// File: rtl/enemy_shot_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : enemy_shot_sched_if
// Desc     : Column requests, slot hit pulses and bullet slot state exchanged
//            with the enemy shot scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface enemy_shot_sched_if #(
    parameter int NUM_COLS  = 8,
    parameter int NUM_SLOTS = 3
);
    logic                    enable;
    logic [NUM_COLS-1:0]     col_valid;
    logic [12*NUM_COLS-1:0]  col_x;
    logic [12*NUM_COLS-1:0]  col_y;
    logic [NUM_SLOTS-1:0]    slot_hit;
    logic [NUM_SLOTS-1:0]    slot_active;
    logic [12*NUM_SLOTS-1:0] slot_x;
    logic [12*NUM_SLOTS-1:0] slot_y;
    logic                    fire;
    logic [3:0]              fire_col;

    modport master (
        output enable,
        output col_valid,
        output col_x,
        output col_y,
        output slot_hit,
        input  slot_active,
        input  slot_x,
        input  slot_y,
        input  fire,
        input  fire_col
    );

    modport slave (
        input  enable,
        input  col_valid,
        input  col_x,
        input  col_y,
        input  slot_hit,
        output slot_active,
        output slot_x,
        output slot_y,
        output fire,
        output fire_col
    );
endinterface

`default_nettype wire

// File: rtl/enemy_shot_sched.sv
`default_nettype none
// ============================================================================
// Module   : enemy_shot_sched
// Desc     : Game-tick driven scheduler that grants alien columns a shared
//            pool of enemy bullet slots and moves the bullets downward.
// Options  : ENEMY_SHOT_LFSR_EN - pseudo-random column search start (LFSR)
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_shot_sched #(
    parameter int NUM_COLS      = 8,
    parameter int NUM_SLOTS     = 3,
    parameter int TICK_DELAY    = 650000,
    parameter int FIRE_INTERVAL = 30,
    parameter int BULLET_SPEED  = 3,
    parameter int BULLET_WIDTH  = 4,
    parameter int BULLET_HEIGHT = 16,
    parameter int ALIEN_WIDTH   = 32,
    parameter int ALIEN_HEIGHT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    enemy_shot_sched_if.slave bus
);

    // Vertical resolution of the VGA timing used by the rest of the game.
    localparam int c_ver_pixels = 480;

    localparam int c_tick_w = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam int c_int_w  = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
    localparam int c_col_w  = $clog2(NUM_COLS);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DELAY);
    localparam logic [c_int_w-1:0]  c_int_last  = c_int_w'(FIRE_INTERVAL - 1);
    localparam logic [11:0]         c_y_limit   = 12'(c_ver_pixels - BULLET_HEIGHT);
    localparam logic [11:0]         c_x_off     = 12'(ALIEN_WIDTH / 2 - BULLET_WIDTH / 2);
    localparam logic [11:0]         c_y_off     = 12'(ALIEN_HEIGHT);
    localparam logic [11:0]         c_speed     = 12'(BULLET_SPEED);

    logic [c_tick_w-1:0]          tick_cnt_q, tick_cnt_d;
    logic [c_int_w-1:0]           int_cnt_q, int_cnt_d;
    logic [NUM_SLOTS-1:0]         hit_q, hit_d;
    logic [NUM_SLOTS-1:0]         slot_active_q, slot_active_d;
    logic [NUM_SLOTS-1:0][11:0]   slot_x_q, slot_x_d;
    logic [NUM_SLOTS-1:0][11:0]   slot_y_q, slot_y_d;
    logic                         fire_q, fire_d;
    logic [3:0]                   fire_col_q, fire_col_d;

    logic                         w_tick;
    logic                         w_tick_en;
    logic [NUM_SLOTS-1:0]         w_hit;
    logic [NUM_SLOTS-1:0]         w_free;
    logic [NUM_SLOTS-1:0]         w_alloc;
    logic [NUM_COLS-1:0][11:0]    w_col_x;
    logic [NUM_COLS-1:0][11:0]    w_col_y;
    logic [c_col_w-1:0]           w_start;
    logic [c_col_w-1:0]           w_idx;
    logic [c_col_w-1:0]           w_grant_col;
    logic                         w_grant_found;
    logic                         w_fire_ok;
    logic                         w_fire_now;

    assign w_col_x = bus.col_x;
    assign w_col_y = bus.col_y;

    // Free-running tick timebase, independent of gameplay enable.
    assign w_tick    = (tick_cnt_q == c_tick_last);
    assign w_tick_en = w_tick & bus.enable;

    always_comb begin
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + c_tick_w'(1);
    end

    // Hits are sticky until consumed by an enabled tick; hits on idle slots drop.
    assign w_hit = hit_q | bus.slot_hit;

    always_comb begin
        hit_d = w_tick_en ? '0 : (w_hit & slot_active_q);
    end

    // Slot occupancy is sampled before this tick's deactivations, so a slot
    // freed on a tick only becomes allocatable on the following tick.
    assign w_free  = ~slot_active_q;
    assign w_alloc = w_free & (~w_free + NUM_SLOTS'(1));

`ifdef ENEMY_SHOT_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (w_tick) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_start = lfsr_q[c_col_w-1:0];
`else
    logic [c_col_w-1:0] last_col_q, last_col_d;

    always_comb begin
        last_col_d = w_fire_now ? w_grant_col : last_col_q;
    end

    // Reset value makes the first search start at column 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_col_q <= c_col_w'(NUM_COLS - 1);
        end else begin
            last_col_q <= last_col_d;
        end
    end

    assign w_start = last_col_q + c_col_w'(1);
`endif

    // Cyclic search from w_start; NUM_COLS is a power of two so the add wraps.
    always_comb begin
        w_grant_col   = '0;
        w_grant_found = 1'b0;
        w_idx         = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            w_idx = w_start + c_col_w'(k);
            if (!w_grant_found && bus.col_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_col   = w_idx;
            end
        end
    end

    assign w_fire_ok  = (int_cnt_q == c_int_last) && (|w_free) && w_grant_found;
    assign w_fire_now = w_tick_en & w_fire_ok;

    always_comb begin
        slot_active_d = slot_active_q;
        slot_x_d      = slot_x_q;
        slot_y_d      = slot_y_q;
        int_cnt_d     = int_cnt_q;
        fire_d        = 1'b0;
        fire_col_d    = fire_col_q;

        if (w_tick_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_active_q[i]) begin
                    if (w_hit[i] || (slot_y_q[i] >= c_y_limit)) begin
                        slot_active_d[i] = 1'b0;
                    end else begin
                        slot_y_d[i] = slot_y_q[i] + c_speed;
                    end
                end
            end

            if (w_fire_now) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (w_alloc[i]) begin
                        slot_active_d[i] = 1'b1;
                        slot_x_d[i]      = w_col_x[w_grant_col] + c_x_off;
                        slot_y_d[i]      = w_col_y[w_grant_col] + c_y_off;
                    end
                end
                int_cnt_d  = '0;
                fire_d     = 1'b1;
                fire_col_d = 4'(w_grant_col);
            end else if (int_cnt_q != c_int_last) begin
                int_cnt_d = int_cnt_q + c_int_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            int_cnt_q     <= '0;
            hit_q         <= '0;
            slot_active_q <= '0;
            slot_x_q      <= '0;
            slot_y_q      <= '0;
            fire_q        <= 1'b0;
            fire_col_q    <= '0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            int_cnt_q     <= int_cnt_d;
            hit_q         <= hit_d;
            slot_active_q <= slot_active_d;
            slot_x_q      <= slot_x_d;
            slot_y_q      <= slot_y_d;
            fire_q        <= fire_d;
            fire_col_q    <= fire_col_d;
        end
    end

    assign bus.slot_active = slot_active_q;
    assign bus.slot_x      = slot_x_q;
    assign bus.slot_y      = slot_y_q;
    assign bus.fire        = fire_q;
    assign bus.fire_col    = fire_col_q;

endmodule

`default_nettype wire

// File: doc/enemy_shot_sched.md
ENEMY_SHOT_SCHED -- requirements
Module: enemy_shot_sched

Interface
REQ-001 SHALL have parameter NUM_COLS, default 8, number of alien columns requesting to fire (power of two, 2..16).
REQ-002 SHALL have parameter NUM_SLOTS, default 3, number of shared enemy bullet slots (1..8).
REQ-003 SHALL have parameter TICK_DELAY, default 650000, clock cycles between game ticks minus one.
REQ-004 SHALL have parameter FIRE_INTERVAL, default 30, minimum ticks between shots (>=1).
REQ-005 SHALL have parameters BULLET_SPEED 3, BULLET_WIDTH 4, BULLET_HEIGHT 16, ALIEN_WIDTH 32, ALIEN_HEIGHT 32 (pixels).
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: enable in 1, gameplay running; col_valid in NUM_COLS, column has a live bottom alien.
REQ-008 SHALL have ports: col_x in 12*NUM_COLS, col_y in 12*NUM_COLS, top-left of each column's bottom alien (slice i = bits 12i+11:12i).
REQ-009 SHALL have port slot_hit in NUM_SLOTS, one-cycle pulse per slot, bullet collided (player or shield).
REQ-010 SHALL have ports slot_active out NUM_SLOTS, slot_x out 12*NUM_SLOTS, slot_y out 12*NUM_SLOTS, all registered.
REQ-011 SHALL have ports fire out 1, one-cycle pulse on allocation; fire_col out 4, granted column index.

Function
REQ-012 SHALL generate tick: counter 0..TICK_DELAY, tick asserted one cycle when counter equals TICK_DELAY, counter then returns to 0 (period TICK_DELAY+1); counter runs regardless of enable.
REQ-013 SHALL latch each slot_hit bit into a sticky pending flag, cleared at the next tick; hit on an inactive slot SHALL be ignored (flag cleared).
REQ-014 On tick with enable, each active slot SHALL: deactivate if hit flag set or slot_y >= VER_PIXELS (vga_pkg) - BULLET_HEIGHT; else slot_y += BULLET_SPEED (12-bit, no wrap possible given the bound check).
REQ-015 SHALL keep an interval counter 0..FIRE_INTERVAL-1 incremented per enabled tick, saturating at FIRE_INTERVAL-1 (fire pending).
REQ-016 On an enabled tick with counter at FIRE_INTERVAL-1, at least one slot free before this tick's deactivations, and any col_valid set: SHALL fire; else SHALL hold pending.
REQ-017 Slots freed on a tick SHALL NOT be reusable until the following tick.
REQ-018 Fire SHALL allocate the lowest-index free slot: slot_x = col_x + ALIEN_WIDTH/2 - BULLET_WIDTH/2, slot_y = col_y + ALIEN_HEIGHT, slot_active = 1, all visible the cycle after tick.
REQ-019 Column grant SHALL search col_valid cyclically from start index S, first set bit wins; fire_col = winner, fire = 1 for exactly one cycle aligned with slot update.
REQ-020 Fire SHALL reset interval counter to 0; non-firing ticks SHALL NOT change grant state.
REQ-021 With enable low: ticks SHALL freeze bullets, interval counter and grant state; hit flags still latch.
REQ-022 col_valid all zero at pending SHALL keep pending; firing occurs on the first enabled tick a column becomes valid.

Reset
REQ-023 rst SHALL clear slot_active, slot_x, slot_y, fire, fire_col, hit flags, tick and interval counters to 0.
REQ-024 rst mid-flight SHALL cancel all bullets within one cycle; round-robin pointer resets to NUM_COLS-1 (first search starts at column 0).

Configuration
REQ-025 Macro ENEMY_SHOT_LFSR_EN defined: S = low log2(NUM_COLS) bits of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset), advanced every tick regardless of enable.
REQ-026 Macro undefined: S = (last granted column + 1) mod NUM_COLS (round-robin); no LFSR logic present.

Verification (TICK_DELAY=3, FIRE_INTERVAL=2, NUM_SLOTS=2, NUM_COLS=4, macro undefined unless stated)
REQ-027 Reset, enable=1, col_valid=4'b1111, col_x[0]=100, col_y[0]=50 -> first fire on 2nd tick, fire_col=0, slot 0 x=114, y=82.
REQ-028 All columns valid, continuous -> fire_col sequence 0,1 then stall (slots full) until a slot frees, next grant 2.
REQ-029 col_valid=4'b0100 only -> every fire_col=2; col_valid=0 -> no fire, fire stays 0 indefinitely.
REQ-030 slot_hit[0] pulse between ticks while slot 0 active -> slot_active[0]=0 after next tick, slot y unchanged; hit on inactive slot -> no effect.
REQ-031 Both slots full, slot 1 reaches bottom on pending tick -> no fire that tick, fire on next tick into slot 1; rst during flight -> all slot_active=0 next cycle.
REQ-032 ENEMY_SHOT_LFSR_EN defined, all columns valid -> fire_col sequence matches LFSR model from seed 8'hA5.
